ps2_rx_scancode: RTL and testbench
==================================

// Module: ps2_rx_scancode
// PURPOSE
//  Parametrised PS/2 device-to-host receiver. Oversamples ps2_clk/ps2_data in the
//  CLK50 domain, deframes start/data/odd-parity/stop, and flags parity, framing and
//  timeout errors. Folds 0xE0/0xF0 prefixes into ext/break flags on the emitted
//  code. Feeds the keypad/LED logic downstream.
// PARAMETERS
//  DATA_W       8       data bits per frame; 7 or 8. Prefix folding only when 8.
//  SYNC_STAGES  2       synchroniser flops on ps2_clk and ps2_data; minimum 2.
//  TIMEOUT_CYC  100000  max CLK50 cycles between ps2_clk falling edges inside a frame.
//  FIFO_DEPTH   8       code FIFO entries, power of 2; used only with PS2_RX_FIFO_EN.
// PORTS
//  CLK50        in   1       system clock, 50 MHz
//  reset        in   1       asynchronous, active-high
//  ps2_clk      in   1       raw PS/2 clock (asynchronous)
//  ps2_data     in   1       raw PS/2 data (asynchronous)
//  code         out  DATA_W  received scancode
//  code_valid   out  1       code/code_ext/code_break are valid
//  code_ext     out  1       code was preceded by 0xE0
//  code_break   out  1       code was preceded by 0xF0 (key release)
//  code_rd      in   1       pop request; FIFO build only, ignored otherwise
//  parity_err   out  1       one-cycle pulse, bad parity
//  frame_err    out  1       one-cycle pulse, bad start or stop bit
//  timeout_err  out  1       one-cycle pulse, watchdog expired mid-frame
//  overflow     out  1       one-cycle pulse, code dropped because FIFO full (0 without FIFO)
// BEHAVIOUR
//  - Reset: state=IDLE; bit counter, watchdog and prefix flags = 0. All outputs 0.
//    FIFO empty. Reset asserted mid-frame discards the partial frame.
//  - Sampling: a falling edge on synchronised ps2_clk (prev=1, cur=0) is the sample
//    strobe. ps2_data is sampled from the same synchronised stage. No other sampling.
//  - Frame: start(0), DATA_W data bits LSB first, parity, stop(1).
//    Parity is odd: the count of ones in data+parity must be odd.
//  - FSM: IDLE --strobe & data=0--> DATA. IDLE --strobe & data=1--> IDLE (no error).
//    DATA shifts DATA_W bits, then --> PARITY --> STOP.
//    STOP strobe --> IDLE and evaluates the frame:
//      stop=0: frame_err pulse.
//      else parity bad: parity_err pulse.
//      else: deliver. frame_err takes priority over parity_err.
//  - Watchdog: in every state other than IDLE it counts CLK50 cycles and is zeroed
//    on each strobe. When it reaches TIMEOUT_CYC-1: state=IDLE, timeout_err pulse,
//    prefix flags cleared. A strobe in the same cycle wins and no timeout fires.
//  - Prefix fold (DATA_W=8):
//      0xE0 sets ext_pend; 0xF0 sets brk_pend; neither is emitted.
//      Any other byte is emitted with code_ext=ext_pend and code_break=brk_pend,
//      then both flags clear.
//      Any error clears both flags. Repeated prefixes are idempotent.
//    DATA_W=7: no folding; code_ext and code_break are tied 0.
//  - Delivery latency: strobe sampling the stop bit on cycle N -> delivery on N+1.
//  - Error pulses occur on cycle N+1 and never coincide with a delivery.
// CONFIGURATION
//  PS2_RX_FIFO_EN defined:
//    - Each delivery is pushed into a FIFO_DEPTH x (DATA_W+2) FIFO.
//    - code/code_ext/code_break show the FIFO head; code_valid = !empty.
//    - code_rd with code_valid pops on the clock edge; code_rd while empty is ignored.
//    - Push to a full FIFO without a pop: entry dropped, overflow pulse.
//    - Push and pop in the same cycle when full: both succeed, no overflow.
//    - Push to an empty FIFO is visible on the following cycle; there is no bypass.
//  PS2_RX_FIFO_EN undefined:
//    - Output registers hold the last delivery; code_valid is a one-cycle pulse on N+1.
//    - code_rd is ignored; overflow is tied 0.
// TESTING
//  1. Frame 0x1C with good parity (p=0) -> code=0x1C, code_valid 1 cycle,
//     ext=0, brk=0, no error pulses.
//  2. Frames F0,1C -> exactly one delivery: code=0x1C, code_break=1, code_ext=0.
//  3. Frames E0,F0,75 -> one delivery: code=0x75, ext=1, brk=1.
//     Next frame 72 -> ext=0, brk=0.
//  4. 0x75 sent with parity=1 -> parity_err pulse, no code_valid.
//     Then F0 + stop=0 frame -> frame_err, and the following 1C arrives with brk=0.
//  5. ps2_clk stops after 4 data bits -> timeout_err exactly TIMEOUT_CYC cycles after
//     the last strobe. Next good 0x29 frame is delivered intact.
//     Reset asserted mid-frame -> all outputs 0 immediately.
//  6. PS2_RX_FIFO_EN, FIFO_DEPTH=8: 9 frames 0x01..0x09 with code_rd=0 -> overflow
//     on the 9th; reads return 0x01..0x08 in order, then code_valid=0.

Source files
------------

// File: rtl/ps2_rx_scancode_if.sv
// Scancode output bus of the PS/2 receiver: code payload, status pulses and the pop request.
// master = receiver side, slave = keypad/LED consumer side.
interface ps2_rx_scancode_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] code;
  logic              code_valid;
  logic              code_ext;
  logic              code_break;
  logic              code_rd;
  logic              parity_err;
  logic              frame_err;
  logic              timeout_err;
  logic              overflow;

  modport master (
    output code, code_valid, code_ext, code_break,
    output parity_err, frame_err, timeout_err, overflow,
    input  code_rd
  );

  modport slave (
    input  code, code_valid, code_ext, code_break,
    input  parity_err, frame_err, timeout_err, overflow,
    output code_rd
  );
endinterface

// File: rtl/ps2_rx_scancode.sv
// PS/2 device-to-host receiver: synchronise, deframe, check odd parity/stop, watchdog,
// fold 0xE0/0xF0 prefixes. Define PS2_RX_FIFO_EN to buffer codes in a FIFO_DEPTH FIFO.
module ps2_rx_scancode #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic             CLK50,
  input  logic             reset,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  ps2_rx_scancode_if.master bus
);
  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYC);
  localparam bit          FOLD  = (DATA_W == 8);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   clk_prev_q;
  logic                   clk_s, dat_s, strobe;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
  logic              perr_q, perr_d, ferr_q, ferr_d, terr_q, terr_d;
  logic              deliver, dlv_ext, dlv_brk;

  // Line idles high, so the chain resets to 1 to avoid a false strobe after reset.
  always_ff @(posedge CLK50 or posedge reset) begin
    if (reset) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q <= clk_s;
    end
  end

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign dat_s  = dat_sync_q[SYNC_STAGES-1];
  assign strobe = clk_prev_q & ~clk_s;

  always_ff @(posedge CLK50 or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      wd_q       <= '0;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      wd_q       <= wd_d;
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      terr_q     <= terr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    wd_d       = wd_q;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
    terr_d     = 1'b0;
    deliver    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        wd_d  = '0;
        if (strobe && !dat_s) state_d = DATA;
      end
      DATA: if (strobe) begin
        shift_d = {dat_s, shift_q[DATA_W-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = PARITY;
      end
      PARITY: if (strobe) begin
        par_d   = dat_s;
        state_d = STOP;
      end
      STOP: if (strobe) begin
        state_d = IDLE;
        if (!dat_s || !(^{shift_q, par_q})) begin
          ferr_d     = ~dat_s;
          perr_d     = dat_s;
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
        end else if (FOLD && shift_q == DATA_W'(8'hE0)) begin
          ext_pend_d = 1'b1;
        end else if (FOLD && shift_q == DATA_W'(8'hF0)) begin
          brk_pend_d = 1'b1;
        end else begin
          deliver    = 1'b1;
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Watchdog: a strobe in the expiry cycle takes precedence.
    if (state_q != IDLE) begin
      if (strobe) begin
        wd_d = '0;
      end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
        state_d    = IDLE;
        wd_d       = '0;
        terr_d     = 1'b1;
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
    end
  end

  assign dlv_ext = FOLD & ext_pend_q;
  assign dlv_brk = FOLD & brk_pend_q;

  assign bus.parity_err  = perr_q;
  assign bus.frame_err   = ferr_q;
  assign bus.timeout_err = terr_q;

`ifdef PS2_RX_FIFO_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [DATA_W+1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W+1:0] head;
  logic [AW:0]       wr_q, rd_q;
  logic              ovf_q, empty, full, pop, push;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = bus.code_rd & ~empty;
  assign push  = deliver & (~full | pop);

  always_ff @(posedge CLK50 or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + (AW+1)'(1);
      if (pop)  rd_q <= rd_q + (AW+1)'(1);
      ovf_q <= deliver & full & ~pop;
    end
  end

  always_ff @(posedge CLK50) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {dlv_ext, dlv_brk, shift_q};
  end

  // Storage is not reset, so the head is masked while empty.
  assign head           = mem_q[rd_q[AW-1:0]];
  assign bus.code       = empty ? '0 : head[DATA_W-1:0];
  assign bus.code_ext   = ~empty & head[DATA_W+1];
  assign bus.code_break = ~empty & head[DATA_W];
  assign bus.code_valid = ~empty;
  assign bus.overflow   = ovf_q;
`else
  logic [DATA_W-1:0] code_q;
  logic              valid_q, ext_q, brk_q;
  logic              unused_rd;

  always_ff @(posedge CLK50 or posedge reset) begin
    if (reset) begin
      code_q  <= '0;
      valid_q <= 1'b0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      valid_q <= deliver;
      if (deliver) begin
        code_q <= shift_q;
        ext_q  <= dlv_ext;
        brk_q  <= dlv_brk;
      end
    end
  end

  assign unused_rd      = bus.code_rd;
  assign bus.code       = code_q;
  assign bus.code_valid = valid_q;
  assign bus.code_ext   = ext_q;
  assign bus.code_break = brk_q;
  assign bus.overflow   = 1'b0;
`endif
endmodule

// File: tb/tb_ps2_rx_scancode.sv
// Directed bench for ps2_rx_scancode; covers the FIFO build when PS2_RX_FIFO_EN is defined.
module tb_ps2_rx_scancode;
  localparam int TO   = 200;
  localparam int SYNC = 2;
  localparam int HALF = 8;

  logic CLK50 = 1'b0;
  logic reset, ps2_clk, ps2_data;

  ps2_rx_scancode_if #(.DATA_W(8)) bus ();

  ps2_rx_scancode #(.DATA_W(8), .SYNC_STAGES(SYNC), .TIMEOUT_CYC(TO), .FIFO_DEPTH(8)) dut (
    .CLK50(CLK50), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .bus(bus)
  );

  always #10 CLK50 = ~CLK50;

  int n_checks = 0, n_fail = 0;
  int n_valid = 0, n_perr = 0, n_ferr = 0, n_terr = 0, n_ovf = 0, n_coinc = 0;
  int s_v, s_p, s_f, s_t, s_o;
  logic [7:0] last_code = '0;
  logic last_ext = 1'b0, last_brk = 1'b0;

  always @(negedge CLK50) begin
    if (!reset) begin
      if (bus.code_valid) begin
        n_valid++;
        last_code = bus.code;
        last_ext  = bus.code_ext;
        last_brk  = bus.code_break;
      end
      if (bus.parity_err)  n_perr++;
      if (bus.frame_err)   n_ferr++;
      if (bus.timeout_err) n_terr++;
      if (bus.overflow)    n_ovf++;
      if (bus.code_valid && (bus.parity_err || bus.frame_err || bus.timeout_err)) n_coinc++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic snap();
    s_v = n_valid; s_p = n_perr; s_f = n_ferr; s_t = n_terr; s_o = n_ovf;
  endtask

  task automatic chk_deltas(input string tag, input int dv, input int dp, input int df, input int dt);
    chk({tag, "_valid"},   n_valid - s_v, dv);
    chk({tag, "_par_err"}, n_perr  - s_p, dp);
    chk({tag, "_frm_err"}, n_ferr  - s_f, df);
    chk({tag, "_to_err"},  n_terr  - s_t, dt);
  endtask

  task automatic send_bit(input logic b);
    @(negedge CLK50);
    ps2_data = b;
    repeat (HALF) @(negedge CLK50);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge CLK50);
    ps2_clk = 1'b1;
  endtask

  // Odd parity bit for d is ~^d; pflip corrupts it.
  task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ pflip);
    send_bit(stop);
    ps2_data = 1'b1;
    repeat (20) @(negedge CLK50);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_code"},  bus.code, 0);
    chk({tag, "_valid"}, bus.code_valid, 0);
    chk({tag, "_ext"},   bus.code_ext, 0);
    chk({tag, "_brk"},   bus.code_break, 0);
    chk({tag, "_perr"},  bus.parity_err, 0);
    chk({tag, "_ferr"},  bus.frame_err, 0);
    chk({tag, "_terr"},  bus.timeout_err, 0);
    chk({tag, "_ovf"},   bus.overflow, 0);
  endtask

  initial begin
    int  cyc;
    logic seen;
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; bus.code_rd = 1'b0;
    repeat (5) @(negedge CLK50);
    reset = 1'b0;
    @(negedge CLK50);
    chk_reset_outputs("rst");

`ifdef PS2_RX_FIFO_EN
    for (int i = 1; i <= 9; i++) begin
      snap();
      send_frame(8'(i), 1'b0, 1'b1);
      if (i == 8) begin
        chk("fifo_no_ovf_at_8", n_ovf, 0);
        chk("fifo_head_at_8", bus.code, 8'h01);
      end
    end
    chk("fifo_ovf_on_9", n_ovf - s_o, 1);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("fifo_valid_%0d", i), bus.code_valid, 1);
      chk($sformatf("fifo_code_%0d", i), bus.code, i);
      bus.code_rd = 1'b1;
      @(negedge CLK50);
      bus.code_rd = 1'b0;
    end
    chk("fifo_empty_valid", bus.code_valid, 0);
    chk("fifo_empty_code", bus.code, 0);
    bus.code_rd = 1'b1;
    repeat (2) @(negedge CLK50);
    bus.code_rd = 1'b0;
    send_frame(8'h0A, 1'b0, 1'b1);
    chk("fifo_after_empty_rd_valid", bus.code_valid, 1);
    chk("fifo_after_empty_rd_code", bus.code, 8'h0A);
`else
    snap(); send_frame(8'h1C, 1'b0, 1'b1);
    chk_deltas("t1", 1, 0, 0, 0);
    chk("t1_code", last_code, 8'h1C);
    chk("t1_ext", last_ext, 0);
    chk("t1_brk", last_brk, 0);

    snap(); send_frame(8'hF0, 1'b0, 1'b1); send_frame(8'h1C, 1'b0, 1'b1);
    chk_deltas("t2", 1, 0, 0, 0);
    chk("t2_code", last_code, 8'h1C);
    chk("t2_ext", last_ext, 0);
    chk("t2_brk", last_brk, 1);

    snap();
    send_frame(8'hE0, 1'b0, 1'b1); send_frame(8'hF0, 1'b0, 1'b1); send_frame(8'h75, 1'b0, 1'b1);
    chk_deltas("t3a", 1, 0, 0, 0);
    chk("t3a_code", last_code, 8'h75);
    chk("t3a_ext", last_ext, 1);
    chk("t3a_brk", last_brk, 1);
    snap(); send_frame(8'h72, 1'b0, 1'b1);
    chk_deltas("t3b", 1, 0, 0, 0);
    chk("t3b_code", last_code, 8'h72);
    chk("t3b_ext", last_ext, 0);
    chk("t3b_brk", last_brk, 0);

    snap(); send_frame(8'h75, 1'b1, 1'b1);
    chk_deltas("t4_par", 0, 1, 0, 0);
    snap(); send_frame(8'hF0, 1'b0, 1'b0);
    chk_deltas("t4_frm", 0, 0, 1, 0);
    snap(); send_frame(8'h1C, 1'b0, 1'b1);
    chk_deltas("t4_after", 1, 0, 0, 0);
    chk("t4_code", last_code, 8'h1C);
    chk("t4_brk", last_brk, 0);

    // Break prefix, then a frame that stalls after four data bits of 0x29.
    snap();
    send_frame(8'hF0, 1'b0, 1'b1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    @(negedge CLK50);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge CLK50);
    ps2_clk = 1'b0;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < TO + 50) begin
      @(negedge CLK50);
      cyc++;
      seen = bus.timeout_err;
    end
    // SYNC flops to see the edge, one edge-detect cycle, TO-1 counts, one pulse register.
    chk("t5_to_latency", cyc, TO + SYNC + 1);
    @(negedge CLK50);
    chk("t5_to_pulse_len", bus.timeout_err, 0);
    ps2_clk = 1'b1;
    repeat (20) @(negedge CLK50);
    chk_deltas("t5_to", 0, 0, 0, 1);
    snap(); send_frame(8'h29, 1'b0, 1'b1);
    chk_deltas("t5_next", 1, 0, 0, 0);
    chk("t5_code", last_code, 8'h29);
    chk("t5_brk", last_brk, 0);
    chk("t5_ext", last_ext, 0);

    send_bit(1'b0); send_bit(1'b1);
    @(negedge CLK50);
    reset = 1'b1;
    #1;
    chk_reset_outputs("rst_mid");
    repeat (3) @(negedge CLK50);
    reset = 1'b0;
    repeat (5) @(negedge CLK50);
    snap(); send_frame(8'h1C, 1'b0, 1'b1);
    chk_deltas("t5_post_rst", 1, 0, 0, 0);
    chk("t5_post_rst_code", last_code, 8'h1C);
    chk("no_err_with_valid", n_coinc, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
